instruction_fetch_stage: RTL and testbench

//  Fetch stage of the RISC-V core; sits directly upstream of instruction_memory.

---
 rtl/instruction_fetch_stage.sv | 67 ++++++
 tb/tb_instruction_fetch_stage.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_stage.sv
// Fetch stage: holds the byte PC, addresses the combinational instruction memory, fills the IF/ID register.
// Latency 1 cycle (one bubble after a redirect); out_ready=0 with out_valid=1 freezes both PC and IF/ID.
module instruction_fetch_stage #(
    parameter int          DATA_WIDTH = 32,
    parameter int          ADDR_WIDTH = 2,
    parameter int          PC_WIDTH   = 32,
    parameter logic [31:0] RESET_PC   = 32'h0,
    parameter logic [31:0] NOP_INSTR  = 32'h00000013
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_instr,
    input  logic                  redirect_valid,
    input  logic [PC_WIDTH-1:0]   redirect_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_instr,
    output logic [PC_WIDTH-1:0]   out_pc,
    output logic [31:0]           fetch_count
);

    logic [PC_WIDTH-1:0]   r_pc;
    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_instr;
    logic [PC_WIDTH-1:0]   r_out_pc;
    logic [31:0]           r_fetch_count;

    logic w_accept;
    logic w_load;

    assign w_accept = r_valid & out_ready;
    assign w_load   = ~r_valid | out_ready;

    // Upper PC bits are dropped, so the small memory aliases across the address space.
    assign imem_addr = r_pc[ADDR_WIDTH+1:2];

    assign out_valid   = r_valid;
    assign out_instr   = r_instr;
    assign out_pc      = r_out_pc;
    assign fetch_count = r_fetch_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc          <= PC_WIDTH'(RESET_PC);
            r_valid       <= 1'b0;
            r_instr       <= DATA_WIDTH'(NOP_INSTR);
            r_out_pc      <= '0;
            r_fetch_count <= '0;
        end else begin
            // A redirect flushes only the slot being refilled; an accept in the same cycle still retires.
            if (redirect_valid) begin
                r_pc    <= {redirect_pc[PC_WIDTH-1:2], 2'b00};
                r_valid <= 1'b0;
            end else if (w_load) begin
                r_instr  <= imem_instr;
                r_out_pc <= r_pc;
                r_valid  <= 1'b1;
                r_pc     <= r_pc + PC_WIDTH'(4);
            end
            if (w_accept) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for instruction_fetch_stage: vector table plus streaming and stall sequences.
module tb_instruction_fetch_stage;

    localparam logic [31:0] IA  = 32'hAAAA0001;
    localparam logic [31:0] IB  = 32'hBBBB0002;
    localparam logic [31:0] IC  = 32'hCCCC0003;
    localparam logic [31:0] ID  = 32'hDDDD0004;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] fetch_count;

    logic [31:0] mem [4];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign imem_instr = mem[imem_addr];

    instruction_fetch_stage dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .fetch_count    (fetch_count)
    );

    typedef struct {
        logic        rst;
        logic        redir;
        logic [31:0] rpc;
        logic        rdy;
        logic        e_vld;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic [1:0]  e_addr;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic rst, input logic redir, input logic [31:0] rpc, input logic rdy,
                       input logic vld, input logic [31:0] pc, input logic [31:0] instr,
                       input logic [1:0] addr, input logic [31:0] cnt);
        vec_t v;
        v.rst = rst; v.redir = redir; v.rpc = rpc; v.rdy = rdy;
        v.e_vld = vld; v.e_pc = pc; v.e_instr = instr; v.e_addr = addr; v.e_cnt = cnt;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic vld, input logic [31:0] pc,
                             input logic [31:0] instr, input logic [1:0] addr, input logic [31:0] cnt);
        chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, vld});
        chk({tag, ".pc"}, out_pc, pc);
        chk({tag, ".instr"}, out_instr, instr);
        chk({tag, ".addr"}, {30'd0, imem_addr}, {30'd0, addr});
        chk({tag, ".count"}, fetch_count, cnt);
    endtask

    task automatic step(input logic rst, input logic redir, input logic [31:0] rpc, input logic rdy);
        @(negedge clk);
        reset = rst; redirect_valid = redir; redirect_pc = rpc; out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] exp_pc;
        logic [31:0] exp_cnt;
        logic        rdy;

        mem[0] = IA; mem[1] = IB; mem[2] = IC; mem[3] = ID;
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;

        //  rst   redir rpc           rdy  | vld  out_pc        instr addr   count
        // Reset, then stream with aliasing at 0x10
        add(1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        NOP, 2'd0, 32'd0);
        add(1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        NOP, 2'd0, 32'd0);
        add(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0,        IA,  2'd1, 32'd0);
        add(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h4,        IB,  2'd2, 32'd1);
        add(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h8,        IC,  2'd3, 32'd2);
        add(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'hC,        ID,  2'd0, 32'd3);
        add(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h10,       IA,  2'd1, 32'd4);
        // Redirect to 4 without accept, then stall 3 cycles at out_pc=4
        add(1'b0, 1'b1, 32'h4,        1'b0, 1'b0, 32'h10,       IA,  2'd1, 32'd4);
        add(1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h4,        IB,  2'd2, 32'd4);
        add(1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h4,        IB,  2'd2, 32'd4);
        add(1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h4,        IB,  2'd2, 32'd4);
        add(1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h4,        IB,  2'd2, 32'd4);
        add(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h8,        IC,  2'd3, 32'd5);
        // Misaligned redirect 0xA with a concurrent accept
        add(1'b0, 1'b1, 32'hA,        1'b1, 1'b0, 32'h8,        IC,  2'd2, 32'd6);
        add(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h8,        IC,  2'd3, 32'd6);
        // Get out_pc=0 presented, then redirect in the cycle it is accepted
        add(1'b0, 1'b1, 32'h0,        1'b0, 1'b0, 32'h8,        IC,  2'd0, 32'd6);
        add(1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0,        IA,  2'd1, 32'd6);
        add(1'b0, 1'b1, 32'h8,        1'b1, 1'b0, 32'h0,        IA,  2'd2, 32'd7);
        add(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h8,        IC,  2'd3, 32'd7);
        // PC wrap through 0xFFFFFFFC
        add(1'b0, 1'b1, 32'hFFFFFFFC, 1'b1, 1'b0, 32'h8,        IC,  2'd3, 32'd8);
        add(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'hFFFFFFFC, ID,  2'd0, 32'd8);
        add(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0,        IA,  2'd1, 32'd9);
        add(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h4,        IB,  2'd2, 32'd10);
        // Reset beats a simultaneous redirect and stall
        add(1'b1, 1'b1, 32'h8,        1'b0, 1'b0, 32'h0,        NOP, 2'd0, 32'd0);
        add(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0,        IA,  2'd1, 32'd0);

        foreach (vq[i]) begin
            step(vq[i].rst, vq[i].redir, vq[i].rpc, vq[i].rdy);
            check_all($sformatf("v%0d", i), vq[i].e_vld, vq[i].e_pc, vq[i].e_instr,
                      vq[i].e_addr, vq[i].e_cnt);
        end

        // Steady streaming: one instruction per cycle, out_pc +4 each cycle
        for (int k = 1; k <= 8; k++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1);
            exp_pc = 32'(k) * 32'd4;
            check_all($sformatf("stream%0d", k), 1'b1, exp_pc, mem[exp_pc[3:2]],
                      2'(exp_pc[3:2] + 2'd1), 32'(k));
        end

        // Alternating ready: every stalled cycle must hold PC, data and count
        exp_pc  = 32'd32;
        exp_cnt = 32'd8;
        for (int k = 0; k < 8; k++) begin
            rdy = (k % 2) == 1;
            step(1'b0, 1'b0, 32'h0, rdy);
            if (rdy) begin
                exp_pc  = exp_pc + 32'd4;
                exp_cnt = exp_cnt + 32'd1;
            end
            check_all($sformatf("alt%0d", k), 1'b1, exp_pc, mem[exp_pc[3:2]],
                      2'(exp_pc[3:2] + 2'd1), exp_cnt);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
